fp_result_collector: RTL and testbench

//  Receiving end of the FP multiplier output interface (ov_Result, o3_OuputID, flags).
//  It captures every valid result and checks that output IDs run in sequence (1..7, wrapping to 1).

---
 rtl/fp_result_collector_if.sv | 41 ++++
 rtl/fp_result_collector.sv | 93 +++++++++
 tb/tb_fp_result_collector.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_result_collector_if.sv
// Capture and drain bus between the FP multiplier, the result collector
// and the downstream consumer. The collector uses the slave view.
interface fp_result_collector_if #(
    parameter int pWidthExp = 8,
    parameter int pWidthMan = 23,
    parameter int pAddrW    = 3
);
    localparam int W = pWidthExp + pWidthMan + 1;

    // capture side (from multiplier)
    logic             i_ClkEn;
    logic [W-1:0]     iv_Result;
    logic [2:0]       i3_OutputID;
    logic             i_Overflow;
    logic             i_Underflow;
    logic             i_NAN;
    // drain side (to consumer)
    logic [W-1:0]     ov_Result;
    logic [2:0]       o3_ID;
    logic [2:0]       o3_Flags;
    logic             o_Valid;
    logic             i_Ready;
    // status / control
    logic [pAddrW:0]  ov_Count;
    logic             o_Full;
    logic             o_SeqErr;
    logic             o_DropErr;
    logic             i_Clear;

    modport master (
        output i_ClkEn, iv_Result, i3_OutputID, i_Overflow, i_Underflow, i_NAN,
        output i_Ready, i_Clear,
        input  ov_Result, o3_ID, o3_Flags, o_Valid, ov_Count, o_Full, o_SeqErr, o_DropErr
    );

    modport slave (
        input  i_ClkEn, iv_Result, i3_OutputID, i_Overflow, i_Underflow, i_NAN,
        input  i_Ready, i_Clear,
        output ov_Result, o3_ID, o3_Flags, o_Valid, ov_Count, o_Full, o_SeqErr, o_DropErr
    );
endinterface

// File: rtl/fp_result_collector.sv
// Collects FP multiplier results into a first-word-fall-through FIFO,
// checks that result IDs run 1..7 cyclically, and flags drops on overflow.
module fp_result_collector #(
    parameter int pPrecision = 1,
    parameter int pWidthExp  = 8,
    parameter int pWidthMan  = 23,
    parameter int pDepth     = 8,
    parameter int pAddrW     = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    fp_result_collector_if.slave  bus
);
    localparam int W = pWidthExp + pWidthMan + 1;
    localparam logic [pAddrW:0] cDepth = (pAddrW+1)'(pDepth);

    // Elaboration guards: precision selector is informational only, and the
    // pointer wrap relies on pDepth being exactly 2**pAddrW.
    if (pPrecision < 0 || pPrecision > 2) begin : gBadPrecision
        $error("pPrecision must be 0, 1 or 2");
    end
    if (pDepth < 2 || pDepth != (1 << pAddrW)) begin : gBadDepth
        $error("pDepth must be a power of two >= 2 and equal 2**pAddrW");
    end

    typedef struct packed {
        logic [2:0]   flags;   // {Overflow, Underflow, NAN}
        logic [2:0]   id;
        logic [W-1:0] result;
    } entry_t;

    entry_t            mem [pDepth];
    entry_t            head;
    logic [pAddrW-1:0] rdPtr, wrPtr;
    logic [pAddrW:0]   count;
    logic [2:0]        expId;
    logic              seqErr, dropErr;
    logic              cap, pop, push, drop, full, valid, seqMis;

    // Capture/drain decode; a full FIFO can still accept when it pops the same cycle
    always_comb begin
        full   = (count == cDepth);
        valid  = (count != '0);
        cap    = bus.i_ClkEn && (bus.i3_OutputID != 3'd0);
        pop    = valid && bus.i_Ready;
        push   = cap && (!full || pop);
        drop   = cap && full && !pop;
        seqMis = cap && (bus.i3_OutputID != expId);
        head   = mem[rdPtr];
    end

    // Pointers, occupancy, expected ID and sticky errors (error set beats clear)
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            expId   <= 3'd1;
            seqErr  <= 1'b0;
            dropErr <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (cap) expId <= (bus.i3_OutputID == 3'd7) ? 3'd1 : bus.i3_OutputID + 3'd1;
            if (seqMis)           seqErr <= 1'b1;
            else if (bus.i_Clear) seqErr <= 1'b0;
            if (drop)             dropErr <= 1'b1;
            else if (bus.i_Clear) dropErr <= 1'b0;
        end
    end

    // Storage write; no reset needed since reads are masked while empty
    always_ff @(posedge i_Clk) begin
        if (!i_Rst && push)
            mem[wrPtr] <= '{flags:  {bus.i_Overflow, bus.i_Underflow, bus.i_NAN},
                            id:     bus.i3_OutputID,
                            result: bus.iv_Result};
    end

    // Head presentation: zeros while empty so reset leaves every output at 0
    always_comb begin
        bus.ov_Result = valid ? head.result : '0;
        bus.o3_ID     = valid ? head.id     : 3'd0;
        bus.o3_Flags  = valid ? head.flags  : 3'd0;
        bus.o_Valid   = valid;
        bus.ov_Count  = count;
        bus.o_Full    = full;
        bus.o_SeqErr  = seqErr;
        bus.o_DropErr = dropErr;
    end
endmodule

// File: tb/tb_fp_result_collector.sv
// Bench for fp_result_collector: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_fp_result_collector;
    localparam int W  = 32;
    localparam int VW = 4 + 4 + 6 + W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_result_collector_if #(.pWidthExp(8), .pWidthMan(23), .pAddrW(3)) bus ();

    fp_result_collector #(
        .pPrecision(1), .pWidthExp(8), .pWidthMan(23), .pDepth(8), .pAddrW(3)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    // reference model
    logic [W+5:0] q[$];
    int           mExp  = 1;
    bit           mSeq  = 0;
    bit           mDrop = 0;

    function automatic logic [VW-1:0] mdl();
        logic [W+5:0] h;
        h = (q.size() != 0) ? q[0] : '0;
        return {4'(q.size()), q.size() != 0, q.size() == 8, mSeq, mDrop, h};
    endfunction

    function automatic logic [VW-1:0] act();
        return {bus.ov_Count, bus.o_Valid, bus.o_Full, bus.o_SeqErr, bus.o_DropErr,
                bus.o3_Flags, bus.o3_ID, bus.ov_Result};
    endfunction

    // advance model with the currently driven inputs, then clock the DUT
    task automatic tick();
        bit cap, pop, push;
        cap = bus.i_ClkEn && bus.i3_OutputID != 0;
        if (rst) begin
            q.delete(); mExp = 1; mSeq = 0; mDrop = 0;
        end else begin
            pop  = q.size() != 0 && bus.i_Ready;
            push = cap && (q.size() < 8 || pop);
            if (bus.i_Clear) begin mSeq = 0; mDrop = 0; end
            if (cap && int'(bus.i3_OutputID) != mExp) mSeq = 1;
            if (cap && !push) mDrop = 1;
            if (cap) mExp = (bus.i3_OutputID == 7) ? 1 : int'(bus.i3_OutputID) + 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({bus.i_Overflow, bus.i_Underflow, bus.i_NAN,
                                   bus.i3_OutputID, bus.iv_Result});
        end
        @(posedge clk); #1;
    endtask

    task automatic present(input logic [2:0] id);
        bus.i_ClkEn     = 1'b1;
        bus.i3_OutputID = id;
        bus.iv_Result   = $urandom;
        {bus.i_Overflow, bus.i_Underflow, bus.i_NAN} = 3'($urandom);
        tick();
        bus.i_ClkEn     = 1'b0;
        bus.i3_OutputID = 3'd0;
    endtask

    task automatic doReset();
        rst = 1'b1; bus.i_Ready = 1'b0; bus.i_Clear = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if (act() !== '0) $display("FAIL reset_outputs act=%h exp=0", act());
        else nPass++;
    endtask

    task automatic test_in_order();
        doReset();
        for (int i = 1; i <= 7; i++) present(3'(i));
        nChecks++;
        if ({bus.ov_Count, bus.o_SeqErr, bus.o_Full} !== {4'd7, 1'b0, 1'b0})
            $display("FAIL fill7 act cnt=%0d seq=%b full=%b exp cnt=7 seq=0 full=0",
                     bus.ov_Count, bus.o_SeqErr, bus.o_Full);
        else nPass++;
        bus.i_Ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            nChecks++;
            if (bus.o3_ID !== 3'(i) || act() !== mdl())
                $display("FAIL drain_%0d act=%h exp=%h id=%0d", i, act(), mdl(), bus.o3_ID);
            else nPass++;
            tick();
        end
        nChecks++;
        if (bus.o_Valid !== 1'b0) $display("FAIL drain_empty act=%b exp=0", bus.o_Valid);
        else nPass++;
        bus.i_Ready = 1'b0;
    endtask

    task automatic test_seq_err();
        doReset();
        present(3'd1); present(3'd2);
        nChecks++;
        if (bus.o_SeqErr !== 1'b0) $display("FAIL seq_before act=%b exp=0", bus.o_SeqErr);
        else nPass++;
        present(3'd4);
        nChecks++;
        if (bus.o_SeqErr !== 1'b1) $display("FAIL seq_after4 act=%b exp=1", bus.o_SeqErr);
        else nPass++;
        present(3'd5);
        nChecks++;
        if (bus.ov_Count !== 4'd4 || act() !== mdl())
            $display("FAIL seq_stored act=%h exp=%h", act(), mdl());
        else nPass++;
    endtask

    task automatic test_drop_and_full_pop();
        logic [W-1:0] headRes;
        doReset();
        for (int i = 1; i <= 7; i++) present(3'(i));
        present(3'd1);
        headRes = bus.ov_Result;
        present(3'd2);
        nChecks++;
        if ({bus.o_DropErr, bus.ov_Count, bus.o_Full, bus.o3_ID, bus.o_SeqErr} !==
            {1'b1, 4'd8, 1'b1, 3'd1, 1'b0} || bus.ov_Result !== headRes)
            $display("FAIL drop act drop=%b cnt=%0d id=%0d exp drop=1 cnt=8 id=1",
                     bus.o_DropErr, bus.ov_Count, bus.o3_ID);
        else nPass++;
        // clear drop flag, then push into a full FIFO while popping
        bus.i_Clear = 1'b1; tick(); bus.i_Clear = 1'b0;
        bus.i_Ready = 1'b1;
        present(3'd3);
        bus.i_Ready = 1'b0;
        nChecks++;
        if ({bus.o_DropErr, bus.ov_Count, bus.o3_ID} !== {1'b0, 4'd8, 3'd2} || act() !== mdl())
            $display("FAIL full_pop act=%h exp=%h", act(), mdl());
        else nPass++;
    endtask

    task automatic test_ignore();
        doReset();
        present(3'd1);
        bus.i_ClkEn = 1'b1; bus.i3_OutputID = 3'd0; tick();
        bus.i_ClkEn = 1'b0; bus.i3_OutputID = 3'd3; tick();
        bus.i3_OutputID = 3'd0;
        nChecks++;
        if (bus.ov_Count !== 4'd1 || bus.o_SeqErr !== 1'b0)
            $display("FAIL ignore act cnt=%0d seq=%b exp cnt=1 seq=0", bus.ov_Count, bus.o_SeqErr);
        else nPass++;
        present(3'd2);
        nChecks++;
        if (bus.o_SeqErr !== 1'b0 || act() !== mdl())
            $display("FAIL ignore_exp act=%h exp=%h", act(), mdl());
        else nPass++;
    endtask

    task automatic test_clear_set_wins();
        doReset();
        present(3'd5);
        bus.i_Clear = 1'b1;
        present(3'd1);
        nChecks++;
        if (bus.o_SeqErr !== 1'b1) $display("FAIL clear_setwins act=%b exp=1", bus.o_SeqErr);
        else nPass++;
        present(3'd2);
        bus.i_Clear = 1'b0;
        nChecks++;
        if (bus.o_SeqErr !== 1'b0 || bus.ov_Count !== 4'd3)
            $display("FAIL clear act seq=%b cnt=%0d exp seq=0 cnt=3", bus.o_SeqErr, bus.ov_Count);
        else nPass++;
    endtask

    task automatic test_mid_reset();
        doReset();
        for (int i = 2; i <= 6; i++) present(3'(i));
        bus.i_Ready = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        nChecks++;
        if (act() !== '0) $display("FAIL mid_reset act=%h exp=0", act());
        else nPass++;
        bus.i_Ready = 1'b0;
        present(3'd1);
        nChecks++;
        if (bus.o_SeqErr !== 1'b0 || bus.ov_Count !== 4'd1)
            $display("FAIL post_reset act seq=%b cnt=%0d exp seq=0 cnt=1", bus.o_SeqErr, bus.ov_Count);
        else nPass++;
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            bus.i_ClkEn     = ($urandom_range(0, 3) != 0);
            bus.i3_OutputID = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'(mExp);
            bus.iv_Result   = $urandom;
            {bus.i_Overflow, bus.i_Underflow, bus.i_NAN} = 3'($urandom);
            bus.i_Ready     = ($urandom_range(0, 2) == 0);
            bus.i_Clear     = ($urandom_range(0, 15) == 0);
            tick();
            nChecks++;
            if (act() !== mdl()) $display("FAIL random_c%0d act=%h exp=%h", c, act(), mdl());
            else nPass++;
        end
        bus.i_ClkEn = 1'b0; bus.i3_OutputID = 3'd0; bus.i_Ready = 1'b0; bus.i_Clear = 1'b0;
    endtask

    initial begin
        bus.i_ClkEn = 1'b0; bus.i3_OutputID = 3'd0; bus.iv_Result = '0;
        bus.i_Overflow = 1'b0; bus.i_Underflow = 1'b0; bus.i_NAN = 1'b0;
        bus.i_Ready = 1'b0; bus.i_Clear = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_in_order();
        test_seq_err();
        test_drop_and_full_pop();
        test_ignore();
        test_clear_set_wins();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
